multi_cycle_control_unit: RTL and testbench

// - Fetch/sequencing stage upstream of the 16-bit RF+ALU datapath: owns PC, instruction register (IR), condition flags and the

---
 rtl/multi_cycle_control_unit_pkg.sv | 66 ++++++
 rtl/multi_cycle_control_unit_if.sv | 47 ++++
 rtl/multi_cycle_control_unit_instr_decoder.sv | 55 +++++
 rtl/multi_cycle_control_unit.sv | 114 +++++++++++
 tb/tb_multi_cycle_control_unit.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared encodings for the 16-bit multi-cycle control unit:
// opcodes, select codes, FSM states and the decoded bundle.
package multi_cycle_control_unit_pkg;

  localparam int DW = 16;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_ADDI = 5'b00010;
  localparam logic [4:0] OP_SUBI = 5'b00011;
  localparam logic [4:0] OP_LDR  = 5'b00101;
  localparam logic [4:0] OP_STR  = 5'b00110;
  localparam logic [4:0] OP_B    = 5'b01000;
  localparam logic [4:0] OP_BEQ  = 5'b01001;
  localparam logic [4:0] OP_BNE  = 5'b01010;
  localparam logic [4:0] OP_BLT  = 5'b01011;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [1:0] BSEL_RF  = 2'b00;
  localparam logic [1:0] BSEL_IMM = 2'b01;
  localparam logic [1:0] IMM_S5   = 2'b00;
  localparam logic [1:0] IMM_S8   = 2'b01;
  localparam logic [1:0] IMM_Z8   = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_WB, S_BRANCH, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_ALU, C_LDR,
    C_STR, C_BR, C_HALT
  } iclass_t;

  // Order matches opcode[1:0] of the branch group.
  typedef enum logic [1:0] {
    BR_AL, BR_EQ, BR_NE, BR_LT
  } brcond_t;

  typedef struct packed {
    iclass_t    cls;
    logic [2:0] rd;
    logic [2:0] rm;
    logic [2:0] rn;
    logic       a_sel;
    logic [1:0] b_sel;
    logic [1:0] imm_sel;
    logic       alu_ctl;
    brcond_t    cond;
  } dec_t;

  function automatic logic br_taken(
    input brcond_t    c,
    input logic [3:0] f
  );
    logic t;
    unique case (c)
      BR_EQ:   t = f[2];
      BR_NE:   t = ~f[2];
      BR_LT:   t = f[3] ^ f[1];
      default: t = 1'b1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// Control unit <-> RF/ALU/memory bundle.
// master = control unit, slave = datapath side.
interface multi_cycle_control_unit_if;
  import multi_cycle_control_unit_pkg::*;

  logic [DW-1:0] Mem_Rdata;
  logic [DW-1:0] ALU_Out;
  logic [3:0]    NZVC;
  logic [DW-1:0] Mem_Addr;
  logic          Mem_Wen;
  logic [DW-1:0] Instr;
  logic [DW-1:0] PC_to_ALU_A;
  logic [2:0]    Rd_to_RF;
  logic [2:0]    Rm_Rd_to_RF;
  logic [2:0]    Rn_to_RF;
  logic          RF_Write_en;
  logic          WB_Sel;
  logic          ALU_A_Sel;
  logic [1:0]    ALU_B_Sel;
  logic [1:0]    Imm_Sel;
  logic          ALU_Control;
  logic          ALUOut_CE;
  logic          Halted;

  modport master (
    input  Mem_Rdata, ALU_Out, NZVC,
    output Mem_Addr, Mem_Wen, Instr,
    output PC_to_ALU_A, Rd_to_RF,
    output Rm_Rd_to_RF, Rn_to_RF,
    output RF_Write_en, WB_Sel,
    output ALU_A_Sel, ALU_B_Sel,
    output Imm_Sel, ALU_Control,
    output ALUOut_CE, Halted
  );

  modport slave (
    output Mem_Rdata, ALU_Out, NZVC,
    input  Mem_Addr, Mem_Wen, Instr,
    input  PC_to_ALU_A, Rd_to_RF,
    input  Rm_Rd_to_RF, Rn_to_RF,
    input  RF_Write_en, WB_Sel,
    input  ALU_A_Sel, ALU_B_Sel,
    input  Imm_Sel, ALU_Control,
    input  ALUOut_CE, Halted
  );

endinterface

// File: rtl/multi_cycle_control_unit_instr_decoder.sv
// Combinational IR decode: class, register indices,
// ALU selects and branch condition.
module multi_cycle_control_unit_instr_decoder
  import multi_cycle_control_unit_pkg::*;
(
  input  logic [15:2] ir_i,
  output dec_t        dec_o
);

  logic [4:0] op;
  assign op = ir_i[15:11];

  always_comb begin
    dec_o         = '0;
    dec_o.cls     = C_NOP;
    dec_o.rd      = ir_i[10:8];
    dec_o.rm      = ir_i[7:5];
    dec_o.rn      = ir_i[4:2];
    dec_o.a_sel   = 1'b1;
    dec_o.b_sel   = BSEL_RF;
    dec_o.imm_sel = IMM_S5;
    dec_o.alu_ctl = 1'b0;
    dec_o.cond    = BR_AL;
    unique case (1'b1)
      (op == OP_ADD) || (op == OP_SUB): begin
        dec_o.cls     = C_ALU;
        dec_o.alu_ctl = op[0];
      end
      (op == OP_ADDI) || (op == OP_SUBI): begin
        dec_o.cls     = C_ALU;
        dec_o.b_sel   = BSEL_IMM;
        dec_o.alu_ctl = op[0];
      end
      op == OP_LDR: begin
        dec_o.cls   = C_LDR;
        dec_o.b_sel = BSEL_IMM;
      end
      op == OP_STR: begin
        dec_o.cls   = C_STR;
        dec_o.b_sel = BSEL_IMM;
      end
      op inside {OP_B, OP_BEQ,
                 OP_BNE, OP_BLT}: begin
        dec_o.cls     = C_BR;
        dec_o.a_sel   = 1'b0;
        dec_o.b_sel   = BSEL_IMM;
        dec_o.imm_sel = IMM_S8;
        dec_o.cond    = brcond_t'(op[1:0]);
      end
      op == OP_HALT: dec_o.cls = C_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle fetch/sequencing FSM: owns PC, IR, flags
// and drives every RF+ALU select and enable.
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic clk,
  input  logic rst,
  multi_cycle_control_unit_if.master bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [3:0]        flags_q;
  logic              rf_we_q;
  logic              mem_we_q;
  logic              alu_ce_q;
  logic              wb_sel_q;
  logic              halted_q;
  logic              st_data_q;
  dec_t              dec;

  multi_cycle_control_unit_instr_decoder u_dec (
    .ir_i  (ir_q[15:2]),
    .dec_o (dec)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (dec.cls)
          C_HALT:  state_d = S_HALT;
          C_NOP:   state_d = S_FETCH;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        unique case (dec.cls)
          C_ALU:        state_d = S_WB;
          C_LDR, C_STR: state_d = S_MEM;
          C_BR:         state_d = S_BRANCH;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM: state_d = (dec.cls == C_LDR)
                     ? S_WB : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are registered off state_d so they
  // are high for exactly the cycle of their state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      flags_q   <= '0;
      rf_we_q   <= 1'b0;
      mem_we_q  <= 1'b0;
      alu_ce_q  <= 1'b0;
      wb_sel_q  <= 1'b0;
      halted_q  <= 1'b0;
      st_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rf_we_q   <= state_d == S_WB;
      alu_ce_q  <= state_d == S_EXEC;
      halted_q  <= state_d == S_HALT;
      wb_sel_q  <= dec.cls == C_LDR;
      mem_we_q  <= (state_d == S_MEM) &&
                   (dec.cls == C_STR);
      st_data_q <= (state_d == S_MEM) &&
                   (dec.cls == C_STR);
      unique case (state_q)
        S_FETCH: begin
          ir_q <= bus.Mem_Rdata;
          pc_q <= pc_q + 1'b1;
        end
        S_EXEC:
          if (dec.cls == C_ALU)
            flags_q <= bus.NZVC;
        S_BRANCH:
          if (br_taken(dec.cond, flags_q))
            pc_q <= bus.ALU_Out;
        default: ;
      endcase
    end
  end

  assign bus.Mem_Addr    = (state_q == S_MEM)
                         ? bus.ALU_Out : pc_q;
  assign bus.Mem_Wen     = mem_we_q;
  assign bus.Instr       = ir_q;
  assign bus.PC_to_ALU_A = pc_q;
  assign bus.Rd_to_RF    = dec.rd;
  assign bus.Rm_Rd_to_RF = st_data_q ? dec.rd : dec.rm;
  assign bus.Rn_to_RF    = dec.rn;
  assign bus.RF_Write_en = rf_we_q;
  assign bus.WB_Sel      = wb_sel_q;
  assign bus.ALU_A_Sel   = dec.a_sel;
  assign bus.ALU_B_Sel   = dec.b_sel;
  assign bus.Imm_Sel     = dec.imm_sel;
  assign bus.ALU_Control = dec.alu_ctl;
  assign bus.ALUOut_CE   = alu_ce_q;
  assign bus.Halted      = halted_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench: small RF/ALU/memory environment
// around the control unit, checked at negedges.
module tb_multi_cycle_control_unit;

  logic clk;
  logic rst;

  multi_cycle_control_unit_if bus ();

  multi_cycle_control_unit #(
    .DATA_W   (16),
    .PC_RESET (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  logic [15:0] rf  [0:7];
  logic [15:0] alu_q;
  logic [15:0] mdr_q;
  int          rfw_cnt  = 0;
  int          memw_cnt = 0;

  logic        pk_en = 1'b0;
  logic        pk_rf = 1'b0;
  logic [7:0]  pk_a  = '0;
  logic [15:0] pk_d  = '0;

  logic [15:0] a_op, b_op, imm, res;
  logic        cy, vf;

  always_comb begin
    a_op = bus.ALU_A_Sel ? rf[bus.Rm_Rd_to_RF]
                         : bus.PC_to_ALU_A;
    case (bus.Imm_Sel)
      2'b00:   imm = {{11{bus.Instr[4]}}, bus.Instr[4:0]};
      2'b01:   imm = {{8{bus.Instr[7]}}, bus.Instr[7:0]};
      default: imm = {8'h00, bus.Instr[7:0]};
    endcase
    b_op = (bus.ALU_B_Sel == 2'b01) ? imm
                                     : rf[bus.Rn_to_RF];
    if (bus.ALU_Control) begin
      {cy, res} = {1'b0, a_op} - {1'b0, b_op};
      vf = (a_op[15] != b_op[15]) && (res[15] != a_op[15]);
    end else begin
      {cy, res} = {1'b0, a_op} + {1'b0, b_op};
      vf = (a_op[15] == b_op[15]) && (res[15] != a_op[15]);
    end
  end

  assign bus.NZVC      = {res[15], res == 16'h0, vf, cy};
  assign bus.ALU_Out   = alu_q;
  assign bus.Mem_Rdata = mem[bus.Mem_Addr[7:0]];

  always @(posedge clk) begin
    mdr_q <= bus.Mem_Rdata;
    if (pk_en) begin
      if (pk_rf) rf[pk_a[2:0]] <= pk_d;
      else       mem[pk_a]     <= pk_d;
    end else begin
      if (bus.ALUOut_CE) alu_q <= res;
      if (bus.RF_Write_en) begin
        rf[bus.Rd_to_RF] <= bus.WB_Sel ? mdr_q : alu_q;
        rfw_cnt <= rfw_cnt + 1;
      end
      if (bus.Mem_Wen) begin
        mem[bus.Mem_Addr[7:0]] <= rf[bus.Rm_Rd_to_RF];
        memw_cnt <= memw_cnt + 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int rw0, mw0;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic poke(input logic is_rf,
                      input logic [7:0] a,
                      input logic [15:0] d);
    @(negedge clk);
    pk_rf = is_rf;
    pk_a  = a;
    pk_d  = d;
    pk_en = 1'b1;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic clear_rf;
    for (int i = 0; i < 8; i++) poke(1'b1, 8'(i), 16'h0);
  endtask

  task automatic go;
    @(negedge clk);
    rst = 1'b0;
    rw0 = rfw_cnt;
    mw0 = memw_cnt;
  endtask

  initial begin
    rst = 1'b1;
    tick(2);
    chk("rst_pc", bus.PC_to_ALU_A, 16'h0000);
    chk("rst_ir", bus.Instr, 16'h0000);
    chk("rst_rfwe", 16'(bus.RF_Write_en), 16'h0);
    chk("rst_memwe", 16'(bus.Mem_Wen), 16'h0);
    chk("rst_alce", 16'(bus.ALUOut_CE), 16'h0);
    chk("rst_halt", 16'(bus.Halted), 16'h0);

    // ADDI R1,R0,#7 ; HALT
    clear_rf();
    poke(1'b0, 8'h00, 16'h1107);
    poke(1'b0, 8'h01, 16'hF800);
    go();
    tick(2);
    chk("addi_ce", 16'(bus.ALUOut_CE), 16'h1);
    chk("addi_wb_early", 16'(bus.RF_Write_en), 16'h0);
    tick(1);
    chk("addi_wb", 16'(bus.RF_Write_en), 16'h1);
    chk("addi_rd", 16'(bus.Rd_to_RF), 16'h1);
    chk("addi_wbsel", 16'(bus.WB_Sel), 16'h0);
    tick(1);
    chk("addi_wb_off", 16'(bus.RF_Write_en), 16'h0);
    chk("addi_r1", rf[1], 16'h0007);
    chk("addi_pc", bus.PC_to_ALU_A, 16'h0001);
    chk("addi_nwr", 16'(rfw_cnt - rw0), 16'h1);
    tick(2);
    chk("halt_on", 16'(bus.Halted), 16'h1);
    chk("halt_pc", bus.PC_to_ALU_A, 16'h0002);
    tick(20);
    chk("halt_pc20", bus.PC_to_ALU_A, 16'h0002);
    chk("halt_on20", 16'(bus.Halted), 16'h1);
    chk("halt_nwr", 16'(rfw_cnt - rw0), 16'h1);

    // SUB R2,R1,R3 ; BLT +3 (taken and not taken)
    for (int k = 0; k < 2; k++) begin
      rst = 1'b1;
      clear_rf();
      poke(1'b1, 8'h01, 16'h0007);
      poke(1'b1, 8'h03, (k == 0) ? 16'h0009 : 16'h0005);
      poke(1'b0, 8'h00, 16'h0A2C);
      poke(1'b0, 8'h01, 16'h5803);
      poke(1'b0, 8'h02, 16'hF800);
      poke(1'b0, 8'h05, 16'hF800);
      go();
      tick(4);
      chk("sub_r2", rf[2], (k == 0) ? 16'hFFFE : 16'h0002);
      tick(4);
      chk("blt_pc", bus.PC_to_ALU_A,
          (k == 0) ? 16'h0005 : 16'h0002);
    end

    // STR R1,[R0+4] ; LDR R4,[R0+4]
    rst = 1'b1;
    clear_rf();
    poke(1'b1, 8'h01, 16'h0007);
    poke(1'b0, 8'h00, 16'h3104);
    poke(1'b0, 8'h01, 16'h2C04);
    poke(1'b0, 8'h02, 16'hF800);
    poke(1'b0, 8'h04, 16'h0000);
    go();
    tick(3);
    chk("str_wen", 16'(bus.Mem_Wen), 16'h1);
    chk("str_addr", bus.Mem_Addr, 16'h0004);
    chk("str_data", rf[bus.Rm_Rd_to_RF], 16'h0007);
    tick(1);
    chk("str_wen_off", 16'(bus.Mem_Wen), 16'h0);
    chk("str_mem", mem[4], 16'h0007);
    chk("str_nwr", 16'(memw_cnt - mw0), 16'h1);
    tick(3);
    chk("ldr_mem_addr", bus.Mem_Addr, 16'h0004);
    chk("ldr_no_wen", 16'(bus.Mem_Wen), 16'h0);
    tick(1);
    chk("ldr_wbsel", 16'(bus.WB_Sel), 16'h1);
    chk("ldr_wb", 16'(bus.RF_Write_en), 16'h1);
    tick(1);
    chk("ldr_r4", rf[4], 16'h0007);
    chk("ldr_pc", bus.PC_to_ALU_A, 16'h0002);
    chk("ldst_nmw", 16'(memw_cnt - mw0), 16'h1);

    // B -2 -> FFFF, illegal NOP there, wrap to 0000
    rst = 1'b1;
    clear_rf();
    poke(1'b0, 8'h00, 16'h40FE);
    poke(1'b0, 8'hFF, 16'hB000);
    go();
    tick(4);
    chk("b_pc_ffff", bus.PC_to_ALU_A, 16'hFFFF);
    chk("b_fetch_addr", bus.Mem_Addr, 16'hFFFF);
    tick(1);
    chk("wrap_pc", bus.PC_to_ALU_A, 16'h0000);
    chk("nop_ir", bus.Instr, 16'hB000);
    tick(1);
    chk("nop_no_exec", 16'(bus.ALUOut_CE), 16'h0);
    chk("nop_fetch_addr", bus.Mem_Addr, 16'h0000);
    tick(1);
    chk("nop_2cyc", bus.Instr, 16'h40FE);
    chk("nop_nrw", 16'(rfw_cnt - rw0), 16'h0);
    chk("nop_nmw", 16'(memw_cnt - mw0), 16'h0);

    // SUB R2,R1,R1 (Z) ; NOP ; BEQ +2 sees stored Z
    rst = 1'b1;
    clear_rf();
    poke(1'b1, 8'h01, 16'h0007);
    poke(1'b0, 8'h00, 16'h0A24);
    poke(1'b0, 8'h01, 16'hB000);
    poke(1'b0, 8'h02, 16'h4802);
    poke(1'b0, 8'h03, 16'hF800);
    poke(1'b0, 8'h05, 16'hF800);
    go();
    tick(10);
    chk("beq_pc", bus.PC_to_ALU_A, 16'h0005);
    chk("beq_nrw", 16'(rfw_cnt - rw0), 16'h1);

    // reset while LDR sits in MEM
    rst = 1'b1;
    clear_rf();
    poke(1'b0, 8'h00, 16'h2C04);
    poke(1'b0, 8'h01, 16'hF800);
    poke(1'b0, 8'h04, 16'h1234);
    go();
    tick(3);
    chk("mid_mem_addr", bus.Mem_Addr, 16'h0004);
    #1 rst = 1'b1;
    #1;
    chk("mid_pc", bus.PC_to_ALU_A, 16'h0000);
    chk("mid_ir", bus.Instr, 16'h0000);
    chk("mid_rfwe", 16'(bus.RF_Write_en), 16'h0);
    chk("mid_addr", bus.Mem_Addr, 16'h0000);
    tick(2);
    chk("mid_r4", rf[4], 16'h0000);
    chk("mid_nrw", 16'(rfw_cnt - rw0), 16'h0);
    go();
    tick(1);
    chk("re_fetch_ir", bus.Instr, 16'h2C04);
    chk("re_fetch_pc", bus.PC_to_ALU_A, 16'h0001);
    tick(4);
    chk("re_ldr_r4", rf[4], 16'h1234);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
